mem_access_arbiter: RTL and testbench

//  Shares the single-port data memory between NUM_CORES processing cores and the host comms port.

---
 rtl/mem_access_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// mem_access_arbiter : shares one single-port data RAM between NUM_CORES cores
//                      and the host port. Optional macro: ARB_HOST_PRIORITY_EN
// Revision           : 1.0
// ============================================================================
module mem_access_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_req,
  input  logic                          host_wr_en,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic                          host_ack,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_wr_en,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(NUM_CORES+1)-1:0] grant_id,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_CORES + 1);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

`ifdef ARB_HOST_PRIORITY_EN
  localparam int RING_N    = NUM_CORES;
  localparam bit HOST_PRIO = 1'b1;
`else
  localparam int RING_N    = NUM_CORES + 1;
  localparam bit HOST_PRIO = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [ID_W-1:0]  HOST_ID  = ID_W'(NUM_CORES);
  localparam logic [ID_W-1:0]  RING_TOP = ID_W'(RING_N - 1);

  logic [1:0]           state_q, state_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 host_ack_q, host_ack_d;
  logic [NUM_CORES-1:0] core_ack_q, core_ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 busy_q, busy_d;

  logic [RING_N-1:0]    ring_req;
  logic                 any_req;
  logic                 hi_found, lo_found;
  logic [ID_W-1:0]      hi_id, lo_id, win_id, rr_next;
  logic                 win_wr;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;

`ifdef ARB_HOST_PRIORITY_EN
  assign ring_req = core_req;
`else
  assign ring_req = {host_req, core_req};
`endif
  assign any_req = host_req | (|core_req);

  // First requester at or above rr_ptr wins; otherwise the lowest one (wrap).
  always_comb begin : arb
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < RING_N; i++) begin
      if (ring_req[i]) begin
        if (!hi_found && (ID_W'(i) >= rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
    if (HOST_PRIO && host_req) begin
      win_id = HOST_ID;
    end
    rr_next = (win_id == RING_TOP) ? '0 : win_id + ID_W'(1);
  end

  always_comb begin : payload
    win_wr    = host_wr_en;
    win_addr  = host_addr;
    win_wdata = host_wdata;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_id == ID_W'(i)) begin
        win_wr    = core_wr_en[i];
        win_addr  = core_addr[i*ADDR_W +: ADDR_W];
        win_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : fsm
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_en_d = 1'b0;
    grant_id_d  = grant_id_q;
    host_ack_d  = 1'b0;
    core_ack_d  = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_ACCESS;
          lat_cnt_d   = '0;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          mem_wr_en_d = win_wr;
          grant_id_d  = win_id;
          busy_d      = 1'b1;
          // A prioritised host does not occupy a ring slot.
          if (!(HOST_PRIO && (win_id == HOST_ID))) begin
            rr_ptr_d = rr_next;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d    = ST_ACK;
          lat_cnt_d  = '0;
          rdata_d    = mem_rdata;
          host_ack_d = (grant_id_q == HOST_ID);
          for (int i = 0; i < NUM_CORES; i++) begin
            core_ack_d[i] = (grant_id_q == ID_W'(i));
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      grant_id_q  <= '0;
      host_ack_q  <= 1'b0;
      core_ack_q  <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      grant_id_q  <= grant_id_d;
      host_ack_q  <= host_ack_d;
      core_ack_q  <= core_ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign host_ack  = host_ack_q;
  assign core_ack  = core_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// tb_mem_access_arbiter: scoreboard bench; main DUT at MEM_LATENCY=1, side DUT at MEM_LATENCY=3.
module tb_mem_access_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int IDW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic           host_req = 1'b0, host_wr_en = 1'b0;
  logic [AW-1:0]  host_addr = '0;
  logic [DW-1:0]  host_wdata = '0;
  logic [NC-1:0]  core_req = '0, core_wr_en = '0;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC*DW-1:0] core_wdata = '0;
  logic           host_ack, mem_wr_en, busy;
  logic [NC-1:0]  core_ack;
  logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic [IDW-1:0] grant_id;

  logic [NC-1:0]    b_core_req = '0;
  logic [NC*AW-1:0] b_core_addr = '0;
  logic           b_host_ack, b_mem_wr_en, b_busy;
  logic [NC-1:0]  b_core_ack;
  logic [DW-1:0]  b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]  b_mem_addr;
  logic [IDW-1:0] b_grant_id;

  mem_access_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_wr_en(host_wr_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  mem_access_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .host_req(1'b0), .host_wr_en(1'b0), .host_addr(16'h0000),
    .host_wdata(16'h0000), .host_ack(b_host_ack),
    .core_req(b_core_req), .core_wr_en(4'b0000), .core_addr(b_core_addr),
    .core_wdata(64'h0), .core_ack(b_core_ack),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wr_en(b_mem_wr_en), .mem_rdata(b_mem_rdata),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main memory model: combinational read, write on the clock edge.
  logic [15:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    ram[8'h40] = 16'hBEEF;
    for (int i = 0; i < NC; i++) ram[8'h80 + i] = 16'(32'hA000 + i);
    ram[8'h90] = 16'hC0DE;
    forever begin
      @(posedge clk);
      if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr[7:0]];
  // Side memory returns a value that changes every cycle, exposing the capture cycle.
  assign b_mem_rdata = {8'hC0, cyc[7:0]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic push(input int id, input bit rd, input logic [15:0] data, input int c);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data; e.cyc = c;
    sb_q.push_back(e);
  endtask

  logic [NC-1:0] prev_core_ack = '0;
  logic          prev_host_ack = 1'b0;
  logic [NC-1:0] auto_core = '0;
  logic          auto_host = 1'b0;
  int            n_acks = 0, wr_count = 0, b_wr_count = 0;
  logic [15:0]   last_wr_addr = '0, last_wr_data = '0;
  exp_t          mon_e;
  int            mon_id;

  always @(negedge clk) begin
    prev_core_ack <= core_ack;
    prev_host_ack <= host_ack;
    if (mem_wr_en) begin
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (b_mem_wr_en) b_wr_count++;
    if (host_ack || (core_ack != '0)) begin
      n_acks++;
      mon_id = host_ack ? NC : 0;
      for (int i = 0; i < NC; i++) if (core_ack[i]) mon_id = i;
      check_eq("ack_onehot", $countones({host_ack, core_ack}), 1);
      check_eq("ack_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_eq("ack_id", mon_id, mon_e.id);
        check_eq("ack_cycle", cyc, mon_e.cyc);
        check_eq("ack_grant_id", grant_id, mon_e.id);
        if (mon_e.rd) check_eq("ack_rdata", rdata, mon_e.data);
      end
    end
  end

  // Advance one cycle; requesters drop req for the cycle after their ack.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (prev_core_ack[i])  core_req[i] = 1'b0;
      else if (auto_core[i]) core_req[i] = 1'b1;
    end
    if (prev_host_ack)  host_req = 1'b0;
    else if (auto_host) host_req = 1'b1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    core_req = '0; host_req = 1'b0; auto_core = '0; auto_host = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, acks0, wr0, bwr0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wr_en", mem_wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_core_ack", core_ack, 0);
    check_eq("rst_host_ack", host_ack, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_grant_id", grant_id, 0);
    step();
    rst = 1'b0;

    // Single core read, latency 1
    step();
    core_addr[1*AW +: AW] = 16'h0040;
    core_req[1] = 1'b1;
    t0 = cyc;
    push(1, 1'b1, 16'hBEEF, t0 + 2);
    @(negedge clk);
    check_eq("t1_idle_busy", busy, 0);
    step();
    @(negedge clk);
    check_eq("t1_mem_addr", mem_addr, 16'h0040);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_mem_wr_en", mem_wr_en, 0);
    step();
    step();
    @(negedge clk);
    check_eq("t1_busy_after", busy, 0);

    // All cores requesting: round-robin from reset
    do_reset();
    for (int i = 0; i < NC; i++) core_addr[i*AW +: AW] = 16'(32'h0080 + i);
    step();
    auto_core = '1; core_req = '1;
    t0 = cyc;
    push(0, 1'b1, 16'hA000, t0 + 2);
    push(1, 1'b1, 16'hA001, t0 + 5);
    push(2, 1'b1, 16'hA002, t0 + 8);
    push(3, 1'b1, 16'hA003, t0 + 11);
    push(0, 1'b1, 16'hA000, t0 + 14);
    repeat (14) step();
    step();
    auto_core = '0; core_req = '0;
    repeat (3) step();

    // Host and all cores requesting from reset
    do_reset();
    host_addr = 16'h0090; host_wr_en = 1'b0;
    step();
    auto_core = '1; auto_host = 1'b1; core_req = '1; host_req = 1'b1;
    t0 = cyc;
`ifdef ARB_HOST_PRIORITY_EN
    push(4, 1'b1, 16'hC0DE, t0 + 2);
    push(0, 1'b1, 16'hA000, t0 + 5);
    push(4, 1'b1, 16'hC0DE, t0 + 8);
    push(1, 1'b1, 16'hA001, t0 + 11);
    push(4, 1'b1, 16'hC0DE, t0 + 14);
    push(2, 1'b1, 16'hA002, t0 + 17);
`else
    push(0, 1'b1, 16'hA000, t0 + 2);
    push(1, 1'b1, 16'hA001, t0 + 5);
    push(2, 1'b1, 16'hA002, t0 + 8);
    push(3, 1'b1, 16'hA003, t0 + 11);
    push(4, 1'b1, 16'hC0DE, t0 + 14);
    push(0, 1'b1, 16'hA000, t0 + 17);
`endif
    repeat (17) step();
    step();
    auto_core = '0; auto_host = 1'b0; core_req = '0; host_req = 1'b0;
    repeat (2) step();

    // Host write competing with core 0, then host read-back
    step();
    host_addr = 16'h0100; host_wr_en = 1'b1; host_wdata = 16'h1234; host_req = 1'b1;
    core_req[0] = 1'b1;
    wr0 = wr_count;
    t0 = cyc;
    push(4, 1'b0, 16'h0000, t0 + 2);
    push(0, 1'b1, 16'hA000, t0 + 5);
    repeat (6) step();
    @(negedge clk);
    check_eq("t3_wr_pulses", wr_count - wr0, 1);
    check_eq("t3_wr_addr", last_wr_addr, 16'h0100);
    check_eq("t3_wr_data", last_wr_data, 16'h1234);
    step();
    host_wr_en = 1'b0; host_req = 1'b1;
    t0 = cyc;
    push(4, 1'b1, 16'h1234, t0 + 2);
    repeat (4) step();

    // Reset during the access cycle of a core write
    step();
    core_addr[2*AW +: AW] = 16'h0088; core_wr_en[2] = 1'b1;
    core_wdata[2*DW +: DW] = 16'h5555; core_req[2] = 1'b1;
    acks0 = n_acks;
    step();
    check_eq("t5_wr_before_rst", mem_wr_en, 1);
    rst = 1'b1;
    core_req = '0; core_wr_en = '0;
    #1;
    check_eq("t5_wr_en", mem_wr_en, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_core_ack", core_ack, 0);
    check_eq("t5_host_ack", host_ack, 0);
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check_eq("t5_no_ack", n_acks - acks0, 0);
    step();
    core_addr[3*AW +: AW] = 16'h0083; core_req[3] = 1'b1;
    t0 = cyc;
    push(3, 1'b1, 16'hA003, t0 + 2);
    repeat (4) step();

    // Latency-3 instance: single read
    step();
    b_core_addr[0 +: AW] = 16'h0081; b_core_req[0] = 1'b1;
    t0 = cyc;
    bwr0 = b_wr_count;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 5) b_core_req = '0;
      @(negedge clk);
      check_eq("t6_ack", b_core_ack, (k == 4) ? 4'b0001 : 4'b0000);
      check_eq("t6_busy", b_busy, (k <= 4) ? 1 : 0);
      check_eq("t6_mem_addr", b_mem_addr, 16'h0081);
      if (k == 4) check_eq("t6_rdata", b_rdata, {8'hC0, 8'(t0 + 3)});
    end
    check_eq("t6_no_write", b_wr_count - bwr0, 0);
    repeat (3) step();

    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
